// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, looked up in IF
// and trained from the resolved branch in EX. Also keeps branch/mispredict perf counters.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_br_type,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branch,
  output logic [31:0] perf_miss
);
  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = 30 - INDEX_W;

  localparam logic [3:0] BT_JIRL = 4'b0011;
  localparam logic [3:0] BT_B    = 4'b0100;
  localparam logic [3:0] BT_BL   = 4'b0101;
  localparam logic [3:0] BT_BGEU = 4'b1011;

  logic [ENTRIES-1:0]       valid;
  logic [ENTRIES-1:0][1:0]  ctr;
  logic [ENTRIES-1:0]       uncond;
  logic [TAG_W-1:0]         tag_q [ENTRIES];
  logic [31:0]              tgt_q [ENTRIES];

  // ---------------- IF lookup ----------------
  logic [INDEX_W-1:0] l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;

  assign l_idx = if_pc[INDEX_W+1:2];
  assign l_tag = if_pc[31:INDEX_W+2];
  assign l_hit = if_valid & valid[l_idx] & (tag_q[l_idx] == l_tag);

  logic l_taken;
  assign l_taken     = l_hit & (uncond[l_idx] | ctr[l_idx][1]);
  assign pred_taken  = rstn & l_taken;
  // Target follows the raw prediction so it stays a pure function of state and if_pc.
  assign pred_target = l_taken ? tgt_q[l_idx] : if_pc + 32'd4;

  // ---------------- EX resolution ----------------
  logic is_branch, is_uncond, miss_raw;

  assign is_branch = (ex_br_type == BT_JIRL) ||
                     ((ex_br_type >= BT_B) && (ex_br_type <= BT_BGEU));
  assign is_uncond = (ex_br_type == BT_JIRL) || (ex_br_type == BT_B) ||
                     (ex_br_type == BT_BL);

  assign miss_raw    = ex_valid & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_target != ex_pred_target)));
  assign mispredict  = rstn & miss_raw;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  // ---------------- training ----------------
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit, upd, wr_entry;
  logic [1:0]         ctr_next;

  assign u_idx    = ex_pc[INDEX_W+1:2];
  assign u_tag    = ex_pc[31:INDEX_W+2];
  assign u_hit    = valid[u_idx] & (tag_q[u_idx] == u_tag);
  assign upd      = ex_valid & is_branch;
  // Taken branches always (re)write tag/target/type; not-taken only touches the counter.
  assign wr_entry = upd & ex_taken;

  always_comb begin
    ctr_next = ctr[u_idx];
    if (ex_taken) begin
      if (!u_hit)                 ctr_next = 2'b10;
      else if (ctr[u_idx] != 2'b11) ctr_next = ctr[u_idx] + 2'd1;
    end else if (ctr[u_idx] != 2'b00) begin
      ctr_next = ctr[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid       <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      perf_branch <= '0;
      perf_miss   <= '0;
    end else begin
      if (wr_entry) valid[u_idx] <= 1'b1;
      if (upd && (ex_taken || u_hit)) ctr[u_idx] <= ctr_next;
      if (upd)        perf_branch <= perf_branch + 32'd1;
      if (mispredict) perf_miss   <= perf_miss + 32'd1;
    end
  end

  // Payload arrays carry no reset; a reset cycle still suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && wr_entry) begin
      tag_q[u_idx]  <= u_tag;
      tgt_q[u_idx]  <= ex_target;
      uncond[u_idx] <= is_uncond;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rstn;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_br_type;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branch;
  logic [31:0] perf_miss;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk(clk), .rstn(rstn),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_branch(perf_branch), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic [3:0] bt, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_br_type = bt; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_br_type = 4'b0000; ex_taken = 1'b0; ex_pred_taken = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    if_valid = 1'b1; if_pc = pc;
    #1;
    chk({tag, ".tk"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, ".tgt"}, pred_target, tgt);
  endtask

  initial begin
    rstn = 1'b0; if_valid = 1'b0; if_pc = '0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
    ex_idle();
    tick(); tick();

    // forced outputs while reset is held
    ex_drive(32'h1C00_0008, 4'b0110, 1'b0, 32'h0, 1'b1, 32'h1C00_0100);
    chk("rst.misp", {31'd0, mispredict}, 32'd0);
    chk("rst.redir", redirect_pc, 32'h1C00_000C);
    ex_idle();
    tick();
    rstn = 1'b1;

    look("init", 32'h1C00_0000, 1'b0, 32'h1C00_0004);
    chk("init.pb", perf_branch, 32'd0);
    chk("init.pm", perf_miss, 32'd0);

    // BEQ taken, predicted not-taken: allocate with ctr=10
    ex_drive(32'h1C00_0010, 4'b0110, 1'b1, 32'h1C00_0040, 1'b0, 32'h1C00_0014);
    chk("beq1.misp", {31'd0, mispredict}, 32'd1);
    chk("beq1.redir", redirect_pc, 32'h1C00_0040);
    tick(); ex_idle();
    chk("beq1.pm", perf_miss, 32'd1);
    look("beq1.look", 32'h1C00_0010, 1'b1, 32'h1C00_0040);

    // same BEQ not taken: ctr 10 -> 01
    ex_drive(32'h1C00_0010, 4'b0110, 1'b0, 32'h1C00_0040, 1'b1, 32'h1C00_0040);
    chk("beq2.misp", {31'd0, mispredict}, 32'd1);
    chk("beq2.redir", redirect_pc, 32'h1C00_0014);
    tick(); ex_idle();
    look("beq2.look", 32'h1C00_0010, 1'b0, 32'h1C00_0014);

    // BNE taken 4x: ctr saturates at 11
    ex_drive(32'h1C00_0020, 4'b0111, 1'b1, 32'h1C00_0080, 1'b0, 32'h1C00_0024);
    tick();
    ex_drive(32'h1C00_0020, 4'b0111, 1'b1, 32'h1C00_0080, 1'b1, 32'h1C00_0080);
    chk("bne.ok", {31'd0, mispredict}, 32'd0);
    tick();
    ex_drive(32'h1C00_0020, 4'b0111, 1'b1, 32'h1C00_0080, 1'b1, 32'h1C00_0084);
    chk("bne.wrongtgt", {31'd0, mispredict}, 32'd1);
    tick();
    ex_drive(32'h1C00_0020, 4'b0111, 1'b1, 32'h1C00_0080, 1'b1, 32'h1C00_0080);
    tick();
    ex_drive(32'h1C00_0020, 4'b0111, 1'b0, 32'h1C00_0080, 1'b1, 32'h1C00_0080);
    tick(); ex_idle();
    look("bne.nt1", 32'h1C00_0020, 1'b1, 32'h1C00_0080);
    ex_drive(32'h1C00_0020, 4'b0111, 1'b0, 32'h1C00_0080, 1'b1, 32'h1C00_0080);
    tick(); ex_idle();
    look("bne.nt2", 32'h1C00_0020, 1'b0, 32'h1C00_0024);
    chk("bne.pb", perf_branch, 32'd8);
    chk("bne.pm", perf_miss, 32'd6);

    // B retrains the 0x10 entry as unconditional; alias 0x110 misses
    ex_drive(32'h1C00_0010, 4'b0100, 1'b1, 32'h1C00_0100, 1'b0, 32'h1C00_0014);
    tick(); ex_idle();
    look("b.look", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
    look("alias", 32'h1C00_0110, 1'b0, 32'h1C00_0114);

    // non-branch predicted taken: mispredict, no training, no branch count
    ex_drive(32'h1C00_0010, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h1C00_0100);
    chk("nb.misp", {31'd0, mispredict}, 32'd1);
    chk("nb.redir", redirect_pc, 32'h1C00_0014);
    tick(); ex_idle();
    look("nb.look", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
    chk("nb.pb", perf_branch, 32'd9);
    chk("nb.pm", perf_miss, 32'd8);

    // undefined type taken: no allocation
    ex_drive(32'h1C00_0050, 4'b0001, 1'b1, 32'h1C00_0200, 1'b0, 32'h1C00_0054);
    tick(); ex_idle();
    look("undef.look", 32'h1C00_0050, 1'b0, 32'h1C00_0054);
    chk("undef.pb", perf_branch, 32'd9);
    chk("idle.misp", {31'd0, mispredict}, 32'd0);

    // same-cycle lookup/update of a fresh JIRL
    ex_drive(32'h1C00_0030, 4'b0011, 1'b1, 32'h1C00_0400, 1'b0, 32'h1C00_0034);
    look("jirl.same", 32'h1C00_0030, 1'b0, 32'h1C00_0034);
    tick(); ex_idle();
    look("jirl.next", 32'h1C00_0030, 1'b1, 32'h1C00_0400);
    chk("jirl.pm", perf_miss, 32'd10);

    // one-cycle reset during a taken update: update dropped, table cleared
    ex_drive(32'h1C00_0060, 4'b0011, 1'b1, 32'h1C00_0500, 1'b0, 32'h1C00_0064);
    rstn = 1'b0;
    look("rst2.look", 32'h1C00_0030, 1'b0, 32'h1C00_0400);
    chk("rst2.misp", {31'd0, mispredict}, 32'd0);
    tick(); ex_idle(); rstn = 1'b1;
    look("rst2.a", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
    look("rst2.b", 32'h1C00_0030, 1'b0, 32'h1C00_0034);
    look("rst2.c", 32'h1C00_0060, 1'b0, 32'h1C00_0064);
    chk("rst2.pb", perf_branch, 32'd0);
    chk("rst2.pm", perf_miss, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side partner of the EX-stage branch resolver. In IF it predicts direction and target for the fetch PC from a direct-mapped BTB with 2-bit saturating counters.
- In EX it takes the resolved outcome (taken flag plus target, using the same 4-bit br_type encoding), raises mispredict/redirect and trains the tables.
- Keeps 32-bit branch and mispredict performance counters.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries; power of two, minimum 4.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- if_valid  in  1  fetch PC valid this cycle
- if_pc  in  32  fetch PC, word aligned
- pred_taken  out  1  predicted taken for if_pc
- pred_target  out  32  predicted next PC
- ex_valid  in  1  EX holds a valid instruction (already flush-qualified)
- ex_pc  in  32  PC of the EX instruction
- ex_br_type  in  4  0000 none, 0011 JIRL, 0100 B, 0101 BL, 0110 BEQ, 0111 BNE, 1000 BLT, 1001 BGE, 1010 BLTU, 1011 BGEU
- ex_taken  in  1  resolved: should branch
- ex_target  in  32  resolved taken target
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  32  predicted next PC carried down the pipe
- mispredict  out  1  EX prediction was wrong
- redirect_pc  out  32  correct next PC when mispredict=1
- perf_branch  out  32  count of resolved branches
- perf_miss  out  32  count of mispredicts

Behaviour:
- Index = pc[INDEX_W+1:2]. Tag = pc[31:INDEX_W+2].
- Each entry holds: valid, tag, target[31:0], uncond (1 bit), ctr[1:0].
- Branch types: valid branch = br_type in {0011, 0100–1011}. Unconditional = {0011, 0100, 0101}.
- Lookup (combinational, reads registered state only):
  - hit = if_valid & valid[idx] & tag match.
  - pred_taken = hit & (uncond | ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4, with 32-bit wrap.
- Resolution (combinational from ex_*):
  - mispredict = ex_valid & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - A non-branch (br_type 0000 or undefined) with ex_pred_taken=1 gives mispredict=1 and redirect to ex_pc+4.
- Update at posedge when ex_valid, a valid branch, and rstn=1. Let uhit be valid & tag match at ex_pc's index.
  - ex_taken=1, uhit: target/uncond overwritten, ctr incremented, saturating at 11.
  - ex_taken=1, miss: entry allocated or overwritten; valid=1, tag, target=ex_target, uncond from type, ctr=10.
  - ex_taken=0, uhit: ctr decremented, saturating at 00; entry stays valid.
  - ex_taken=0, miss: no change.
  - Non-branch or undefined type: no table update, even on mispredict.
- Same-cycle lookup and update to the same index: lookup sees the pre-update entry, no bypass. The update is visible the next cycle.
- Perf counters: perf_branch +1 per valid-branch resolution. perf_miss +1 whenever mispredict=1, including non-branch aliasing. Both wrap modulo 2^32.
- Reset (rstn=0 at posedge):
  - all valid cleared, all ctr set to 01, perf counters set to 0; tag/target arrays are not reset.
  - While rstn=0, pred_taken and mispredict are forced to 0.
  - redirect_pc and pred_target still follow their equations.
  - A reset asserted in the same cycle as an update takes precedence: the update is dropped.
- No stall input: a held if_pc simply re-reads the same result. The pipeline must not present ex_valid twice for one instruction.

Test Plan:
- Reset, then if_valid=1, if_pc=0x1C000000 -> pred_taken=0, pred_target=0x1C000004, perf_branch=0, perf_miss=0.
- BEQ at 0x1C000010: ex_taken=1, ex_target=0x1C000040, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x1C000040, perf_miss=1. Next cycle if_pc=0x1C000010 -> pred_taken=1, pred_target=0x1C000040.
- Same BEQ then resolved not-taken with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x1C000014, ctr 10->01. Next lookup -> pred_taken=0, pred_target=0x1C000014.
- BNE at 0x1C000020 taken 4 times (ctr 11), then not-taken once -> lookup still pred_taken=1. Second not-taken -> pred_taken=0.
- Aliasing, ENTRIES=64: B at 0x1C000010 allocated; lookup 0x1C000110 -> miss, pred_taken=0. Non-branch at 0x1C000010 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x1C000014, entry still valid, perf_branch unchanged.
- Same-cycle lookup and update of 0x1C000030 (first taken JIRL) -> pred_taken=0 that cycle, 1 next cycle. Then rstn=0 for one cycle during a taken update -> all lookups miss afterwards, perf counters=0.
